// File: rtl/image_rect_addr_gen.sv
// Rectangle address walker: turns upper-left/lower-right framebuffer addresses into a row-major beat stream.
// Latency: first beat (floor(ul/H_RES)+1)+(floor(lr/H_RES)+1)+2 cycles after start; then one beat per accepted cycle.
// Backpressure: valid/ready; beat fields are frozen while pix_valid=1 and pix_ready=0.
//
// Ports: clk/resetn (async active-low); start + ul_addr/lr_addr request a walk (sampled only in IDLE);
//        pix_valid/pix_ready/pix_addr/img_addr/last carry the beat stream;
//        busy marks a walk in progress, done pulses one cycle at the end, err flags a rejected request.
module image_rect_addr_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [18:0] ul_addr,
    input  logic [18:0] lr_addr,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [18:0] pix_addr,
    output logic [18:0] img_addr,
    output logic        last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [18:0] H_W  = 19'(H_RES);
    localparam logic [18:0] NPIX = 19'(H_RES * V_RES);

    typedef enum logic [2:0] {IDLE, MOD_UL, MOD_LR, CHECK, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [18:0] ul_q, ul_d;
    logic [18:0] lr_q, lr_d;
    logic [18:0] rem_q, rem_d;          // running remainder shared by both column divisions
    logic [18:0] ul_col_q, ul_col_d;
    logic [18:0] lr_col_q, lr_col_d;
    logic [18:0] pix_addr_q, pix_addr_d;
    logic [18:0] row_start_q, row_start_d;
    logic [18:0] col_cnt_q, col_cnt_d;
    logic [18:0] img_addr_q, img_addr_d;
    logic [18:0] width_m1_q, width_m1_d;
    logic        err_q, err_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ul_q        <= '0;
            lr_q        <= '0;
            rem_q       <= '0;
            ul_col_q    <= '0;
            lr_col_q    <= '0;
            pix_addr_q  <= '0;
            row_start_q <= '0;
            col_cnt_q   <= '0;
            img_addr_q  <= '0;
            width_m1_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ul_q        <= ul_d;
            lr_q        <= lr_d;
            rem_q       <= rem_d;
            ul_col_q    <= ul_col_d;
            lr_col_q    <= lr_col_d;
            pix_addr_q  <= pix_addr_d;
            row_start_q <= row_start_d;
            col_cnt_q   <= col_cnt_d;
            img_addr_q  <= img_addr_d;
            width_m1_q  <= width_m1_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        ul_d        = ul_q;
        lr_d        = lr_q;
        rem_d       = rem_q;
        ul_col_d    = ul_col_q;
        lr_col_d    = lr_col_q;
        pix_addr_d  = pix_addr_q;
        row_start_d = row_start_q;
        col_cnt_d   = col_cnt_q;
        img_addr_d  = img_addr_q;
        width_m1_d  = width_m1_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ul_d  = ul_addr;
                    lr_d  = lr_addr;
                    rem_d = ul_addr;
                    err_d = 1'b0;
                    if (ul_addr >= NPIX || lr_addr >= NPIX || lr_addr < ul_addr) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = MOD_UL;
                    end
                end
            end
            MOD_UL: begin
                if (rem_q >= H_W) begin
                    rem_d = rem_q - H_W;
                end else begin
                    ul_col_d = rem_q;
                    rem_d    = lr_q;   // preload the second division
                    state_d  = MOD_LR;
                end
            end
            MOD_LR: begin
                if (rem_q >= H_W) begin
                    rem_d = rem_q - H_W;
                end else begin
                    lr_col_d = rem_q;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                // Address order alone cannot reject a rectangle whose right edge lies left of its left edge.
                if (lr_col_q < ul_col_q) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    pix_addr_d  = ul_q;
                    row_start_d = ul_q;
                    col_cnt_d   = '0;
                    img_addr_d  = '0;
                    width_m1_d  = lr_col_q - ul_col_q;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (pix_ready) begin
                    img_addr_d = img_addr_q + 19'd1;
                    if (pix_addr_q == lr_q) begin
                        state_d = DONE;
                    end else if (col_cnt_q == width_m1_q) begin
                        row_start_d = row_start_q + H_W;
                        pix_addr_d  = row_start_q + H_W;
                        col_cnt_d   = '0;
                    end else begin
                        pix_addr_d = pix_addr_q + 19'd1;
                        col_cnt_d  = col_cnt_q + 19'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        pix_valid = (state_q == RUN);
        busy      = (state_q == MOD_UL) || (state_q == MOD_LR) || (state_q == CHECK) || (state_q == RUN);
        done      = (state_q == DONE);
        last      = (state_q == RUN) && (pix_addr_q == lr_q);
        pix_addr  = pix_addr_q;
        img_addr  = img_addr_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_image_rect_addr_gen.sv
// Self-checking bench for image_rect_addr_gen: directed scenarios plus randomized rectangles against a geometric model.
// Latency: n/a (bench).
// Backpressure: pix_ready held high or randomized per scenario.
module tb_image_rect_addr_gen;

    localparam int H = 640;
    localparam int V = 480;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [18:0] ul_addr = '0;
    logic [18:0] lr_addr = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [18:0] pix_addr;
    logic [18:0] img_addr;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    image_rect_addr_gen #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .ul_addr(ul_addr), .lr_addr(lr_addr),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_addr(pix_addr), .img_addr(img_addr), .last(last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(pix_valid), 0);
        check_eq({tag, "_paddr"}, 32'(pix_addr), 0);
        check_eq({tag, "_iaddr"}, 32'(img_addr), 0);
        check_eq({tag, "_last"},  32'(last), 0);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_done"},  32'(done), 0);
        check_eq({tag, "_err"},   32'(err), 0);
    endtask

    // Runs one request from a negedge and checks it against a geometric model of the rectangle.
    // rnd_rdy: randomize pix_ready; inj_mod/inj_beat: stray start pulses; abort_beat: reset at that beat.
    task automatic run_walk(input int ul, input int lr, input bit rnd_rdy,
                            input bit inj_mod, input int inj_beat, input int abort_beat);
        int  exp_q[$];
        int  ur, uc, lrw, lc, lat, n, budget, c, beat, last_xfer_c;
        bit  pre_err, col_err, exp_err, finished, aborted, seen_valid;
        exp_q.delete();
        pre_err = !(ul < NPIX && lr < NPIX && lr >= ul);
        ur = ul / H; uc = ul % H; lrw = lr / H; lc = lr % H;
        col_err = !pre_err && (lc < uc);
        exp_err = pre_err || col_err;
        lat = ur + lrw + 4;
        if (!exp_err)
            for (int r = ur; r <= lrw; r++)
                for (int k = uc; k <= lc; k++)
                    exp_q.push_back(r * H + k);
        n = exp_q.size();
        budget = lat + 8 * n + 50;

        ul_addr = 19'(ul); lr_addr = 19'(lr); start = 1'b1;
        c = 0; beat = 0; last_xfer_c = 0;
        finished = 0; aborted = 0; seen_valid = 0;
        @(negedge clk);
        c = 1;
        while (!finished && !aborted && c <= budget) begin
            start = 1'b0;
            pix_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inj_mod && c == 1 && !exp_err) begin
                start = 1'b1;
                ul_addr = 19'($urandom_range(0, NPIX - 1));
                lr_addr = 19'($urandom_range(0, NPIX - 1));
            end
            if (done) begin
                check_eq("done_err", 32'(err), 32'(exp_err));
                check_eq("done_busy", 32'(busy), 0);
                if (pre_err)      check_eq("done_cyc", 32'(c), 1);
                else if (col_err) check_eq("done_cyc", 32'(c), 32'(lat));
                else begin
                    check_eq("done_cyc", 32'(c), 32'(last_xfer_c + 1));
                    check_eq("nbeats", 32'(beat), 32'(n));
                end
                finished = 1;
            end else begin
                check_eq("busy", 32'(busy), 1);
                if (c == 1) check_eq("err_clr", 32'(err), 0);
                if (pix_valid) begin
                    if (!seen_valid) begin
                        check_eq("first_lat", 32'(c), 32'(lat));
                        seen_valid = 1;
                    end
                    if (beat >= n) begin
                        check_eq("extra_beat", 32'(pix_valid), 0);
                        finished = 1;
                    end else begin
                        check_eq("pix_addr", 32'(pix_addr), 32'(exp_q[beat]));
                        check_eq("img_addr", 32'(img_addr), 32'(beat));
                        check_eq("last", 32'(last), 32'(beat == n - 1));
                        if (beat == abort_beat) begin
                            #3 resetn = 1'b0;
                            #1 check_all_zero("arst");
                            for (int i = 0; i < 3; i++) begin
                                @(negedge clk);
                                check_eq("arst_nodone", 32'(done), 0);
                            end
                            resetn = 1'b1;
                            aborted = 1;
                        end else begin
                            if (beat == inj_beat) begin
                                start = 1'b1;
                                ul_addr = 19'($urandom_range(0, NPIX - 1));
                                lr_addr = 19'($urandom_range(0, NPIX - 1));
                            end
                            if (pix_ready) begin
                                beat++;
                                last_xfer_c = c;
                            end
                        end
                    end
                end
            end
            if (!finished && !aborted) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        if (!finished && !aborted) check_eq("timeout", 1, 0);
        if (finished) begin
            @(negedge clk);
            check_eq("idle_busy", 32'(busy), 0);
            check_eq("idle_done", 32'(done), 0);
            check_eq("idle_valid", 32'(pix_valid), 0);
            check_eq("err_hold", 32'(err), 32'(exp_err));
        end
    endtask

    initial begin
        int ur, uc, h, w, ul, lr;
        #1 check_all_zero("rst");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");

        run_walk(0, 0, 0, 0, -1, -1);
        run_walk(168288, 185592, 0, 0, -1, -1);
        run_walk(640, 1281, 1, 0, -1, -1);
        run_walk(700, 650, 0, 0, -1, -1);
        run_walk(1279, 1920, 0, 0, -1, -1);
        run_walk(168288, 185592, 0, 0, -1, 10);
        @(negedge clk);
        check_all_zero("after_abort");
        run_walk(168288, 185592, 0, 0, -1, -1);
        run_walk(640, 1281, 1, 1, 2, -1);
        run_walk(NPIX, NPIX + 5, 0, 0, -1, -1);
        run_walk(5, NPIX, 0, 0, -1, -1);
        run_walk(NPIX - 1, NPIX - 1, 1, 0, -1, -1);

        for (int i = 0; i < 14; i++) begin
            ur = $urandom_range(0, 470);
            h  = $urandom_range(1, 6);
            uc = $urandom_range(0, 630);
            w  = $urandom_range(1, 8);
            ul = ur * H + uc;
            lr = (ur + h - 1) * H + uc + w - 1;
            case ($urandom_range(0, 5))
                0: run_walk(lr, ul > 0 ? ul - 1 : 0, 1, 0, -1, -1);
                1: run_walk(ul + w, lr + H - w, 1, 0, -1, -1);
                default: run_walk(ul, lr, 1, 1, $urandom_range(0, 5), -1);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
